// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    // High-phase length for the rising-edge-only output: ceil(div/2).
    function automatic int unsigned half_ceil(input int unsigned div);
        return (div >> 1) + (div & 32'd1);
    endfunction

    function automatic logic div_valid(input int unsigned div);
        return div >= DIV_MIN;
    endfunction

endpackage

// File: rtl/odd_duty_stage.sv
// Falling-edge re-sample of the high term, OR-ed in to stretch odd divisors to 50 % duty.
// Present only when PROG_CLK_DIV_ODD_DUTY50_EN is defined.
`ifdef PROG_CLK_DIV_ODD_DUTY50_EN
module odd_duty_stage (
    input  logic clk,
    input  logic rst,
    input  logic hi_in,
    input  logic odd_en,
    output logic out_clk
);

    logic hi_f;

    always_ff @(negedge clk) begin
        if (rst) hi_f <= 1'b0;
        else     hi_f <= hi_in;
    end

    // hi_f lags by half a cycle; masking with rst keeps the output low from the reset edge on.
    assign out_clk = hi_in | (hi_f & odd_en & ~rst);

endmodule
`endif

// File: rtl/prog_clk_div.sv
// Runtime-programmable integer clock divider with period-boundary divisor loads.
// Define PROG_CLK_DIV_ODD_DUTY50_EN for exact 50 % duty on odd divisors.
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] div_cur,
    output logic             out_clk,
    output logic             out_tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] hi_thr;
    logic             pend_vld;
    logic             hi_r;
    logic             load_ok;
    logic             wrap;

    assign load_ok = div_load & div_valid(32'(div_in));
    assign wrap    = (cnt == div_cur - CNT_W'(1));

    always_comb begin
        hi_thr = CNT_W'(half_ceil(32'(div_cur)));
`ifdef PROG_CLK_DIV_ODD_DUTY50_EN
        // Odd N: one cycle shorter here, the falling-edge stage adds the missing half.
        if (div_cur[0]) hi_thr = div_cur >> 1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            div_cur  <= CNT_W'(DEFAULT_DIV);
            hi_r     <= 1'b0;
            out_tick <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            hi_r     <= (cnt < hi_thr);
            out_tick <= (cnt == '0);
            div_err  <= div_load & ~load_ok;
            div_ack  <= 1'b0;
            if (wrap) begin
                cnt <= '0;
                // A valid load on the wrap cycle itself overrides the pending value.
                if (load_ok || pend_vld) begin
                    div_cur  <= load_ok ? div_in : pend;
                    pend_vld <= 1'b0;
                    div_ack  <= 1'b1;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (load_ok) begin
                    pend     <= div_in;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

`ifdef PROG_CLK_DIV_ODD_DUTY50_EN
    odd_duty_stage u_odd_duty (
        .clk     (clk),
        .rst     (rst),
        .hi_in   (hi_r),
        .odd_en  (div_cur[0]),
        .out_clk (out_clk)
    );
`else
    assign out_clk = hi_r;
`endif

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: per-cycle expected outputs queued, then popped against the DUT.
`timescale 1ns/1ps
module tb_prog_clk_div;

    typedef struct packed {
        logic       oclk;
        logic       tick;
        logic       ack;
        logic       err;
        logic [7:0] cur;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] div_in = 8'd0;
    logic       div_load = 1'b0;
    logic       div_ack, div_err, out_clk, out_tick;
    logic [7:0] div_cur;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    real  t_rise = 0.0;
    real  hi_w = 0.0;

    prog_clk_div #(.CNT_W(8), .DEFAULT_DIV(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .div_cur  (div_cur),
        .out_clk  (out_clk),
        .out_tick (out_tick)
    );

    always #5 clk = ~clk;

    always @(posedge out_clk) t_rise = $realtime;
    always @(negedge out_clk) hi_w = $realtime - t_rise;

    // One full output period of length n: ceil(n/2) high, tick on the first cycle;
    // if ack_end, the last cycle shows div_ack and the newly applied divisor.
    task automatic push_period(input int n, input bit ack_end, input int nxt);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e.oclk = (i < (n + 1) / 2);
            e.tick = (i == 0);
            e.err  = 1'b0;
            e.ack  = ack_end && (i == n - 1);
            e.cur  = (ack_end && (i == n - 1)) ? 8'(nxt) : 8'(n);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_one(input logic oc, input logic tk, input int cur);
        obs_t e;
        e.oclk = oc; e.tick = tk; e.ack = 1'b0; e.err = 1'b0; e.cur = 8'(cur);
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        obs_t e, got;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) push_one(1'b0, 1'b0, 6);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {out_clk, out_tick, div_ack, div_err, div_cur};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset cyc %0d: got=%h want=%h (clk,tick,ack,err,cur)", i, got, e);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_default;
        obs_t e, got;
        int n;
        for (int p = 0; p < 3; p++) push_period(6, 1'b0, 6);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {out_clk, out_tick, div_ack, div_err, div_cur};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL default6 cyc %0d: got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_load5;
        obs_t e, got;
        int n;
        int want_w;
        push_period(6, 1'b1, 5);
        push_period(5, 1'b0, 5);
        push_period(5, 1'b0, 5);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            div_load = (i == 0);
            div_in   = 8'd5;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {out_clk, out_tick, div_ack, div_err, div_cur};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load5 cyc %0d: got=%h want=%h", i, got, e);
            end
        end
        div_load = 1'b0;
`ifdef PROG_CLK_DIV_ODD_DUTY50_EN
        want_w = 25;
`else
        want_w = 30;
`endif
        checks++;
        if (int'(hi_w) != want_w) begin
            errors++;
            $display("FAIL load5 high_width: got=%0d ns want=%0d ns", int'(hi_w), want_w);
        end
    endtask

    task automatic test_load4_mid;
        obs_t e, got;
        int n;
        push_period(5, 1'b1, 6);
        push_period(6, 1'b1, 4);
        push_period(4, 1'b0, 4);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            div_load = (i == 0) || (i == 7);
            div_in   = (i == 0) ? 8'd6 : 8'd4;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {out_clk, out_tick, div_ack, div_err, div_cur};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load4_mid cyc %0d: got=%h want=%h", i, got, e);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_err;
        obs_t e, got;
        int n;
        push_period(4, 1'b1, 6);
        push_period(6, 1'b0, 6);
        push_period(6, 1'b0, 6);
        for (int k = 5; k <= 6; k++) begin
            e = exp_q[k]; e.err = 1'b1; exp_q[k] = e;
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            div_load = (i == 0) || (i == 5) || (i == 6);
            div_in   = (i == 0) ? 8'd6 : (i == 5) ? 8'd0 : 8'd1;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {out_clk, out_tick, div_ack, div_err, div_cur};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL div_err cyc %0d: got=%h want=%h", i, got, e);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_back_to_back;
        obs_t e, got;
        int n;
        push_period(6, 1'b1, 8);
        push_period(8, 1'b0, 8);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            div_load = (i == 1) || (i == 2);
            div_in   = (i == 1) ? 8'd4 : 8'd8;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {out_clk, out_tick, div_ack, div_err, div_cur};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got=%h want=%h", i, got, e);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_reset_mid;
        obs_t e, got;
        int n;
        push_period(8, 1'b1, 6);
        push_one(1'b1, 1'b1, 6);
        push_one(1'b0, 1'b0, 6);
        push_one(1'b0, 1'b0, 6);
        push_period(6, 1'b0, 6);
        push_period(6, 1'b0, 6);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            div_load = (i == 0) || (i == 8);
            div_in   = (i == 0) ? 8'd6 : 8'd4;
            rst      = (i == 9) || (i == 10);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {out_clk, out_tick, div_ack, div_err, div_cur};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got=%h want=%h", i, got, e);
            end
        end
        div_load = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_load5();
        test_load4_mid();
        test_err();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
